// File: rtl/bin_count_sample_streamer.sv
// Streams stored NUM_BINS-bin spectra from a synchronous sample ROM to the spiking network and collects one winner per sample.
// Optional label scoring (label_addr/label_data/result_correct/correct_cnt) is built when LABEL_CHECK_EN is defined.
module bin_count_sample_streamer #(
    parameter int NUM_BINS    = 1024,
    parameter int NUM_SAMPLES = 100,
    parameter int ROM_AW      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              rom_rd_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [19:0]       rom_data,
    input  logic              request_new_sample,
    input  logic              infer_ready,
    input  logic [4:0]        winner_ID,
    output logic              trans_start,
    output logic [19:0]       bin_cnt,
    output logic              busy,
    output logic              result_valid,
    output logic [15:0]       result_idx,
    output logic [4:0]        result_winner,
`ifdef LABEL_CHECK_EN
    output logic [15:0]       label_addr,
    input  logic [4:0]        label_data,
    output logic              result_correct,
    output logic [15:0]       correct_cnt,
`endif
    output logic              batch_done
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_REQ = 3'd1;
    localparam logic [2:0] ST_FETCH    = 3'd2;
    localparam logic [2:0] ST_STREAM   = 3'd3;
    localparam logic [2:0] ST_WAIT_RES = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Counter spans the NUM_BINS reads plus the two-cycle ROM/output pipeline drain.
    localparam int CW = $clog2(NUM_BINS + 2);

    logic [2:0]        state_q, state_d;
    logic [15:0]       sample_idx_q, sample_idx_d;
    logic [ROM_AW-1:0] base_q, base_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              req_pend_q, req_pend_d;
    logic              infer_q;
    logic              rd_d1_q;
    logic              first_d1_q;
    logic [19:0]       bin_cnt_q;
    logic              trans_start_q;
    logic              result_valid_q;
    logic [15:0]       result_idx_q;
    logic [4:0]        result_winner_q;
    logic              batch_done_q;

    logic              rd_en;
    logic              capture;
    logic [15:0]       next_idx;

    assign rd_en    = (state_q == ST_FETCH) ||
                      ((state_q == ST_STREAM) && (rd_cnt_q < CW'(NUM_BINS)));
    assign capture  = (state_q == ST_WAIT_RES) && infer_ready && !infer_q;
    assign next_idx = sample_idx_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        sample_idx_d = sample_idx_q;
        base_d       = base_q;
        addr_d       = addr_q;
        rd_cnt_d     = rd_cnt_q;
        req_pend_d   = req_pend_q;
        if (request_new_sample && (state_q != ST_FETCH) && (state_q != ST_STREAM))
            req_pend_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d      = ST_WAIT_REQ;
                    sample_idx_d = '0;
                    base_d       = '0;
                end
            end
            ST_WAIT_REQ: begin
                if (req_pend_q || request_new_sample) begin
                    state_d    = ST_FETCH;
                    req_pend_d = 1'b0;
                    addr_d     = base_q;
                    rd_cnt_d   = '0;
                end
            end
            ST_FETCH, ST_STREAM: begin
                rd_cnt_d = rd_cnt_q + CW'(1);
                if (rd_en)
                    addr_d = addr_q + ROM_AW'(1);
                state_d = ST_STREAM;
                if ((state_q == ST_STREAM) && (rd_cnt_q == CW'(NUM_BINS + 1)))
                    state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (capture) begin
                    sample_idx_d = next_idx;
                    base_d       = base_q + ROM_AW'(NUM_BINS);
                    state_d      = (next_idx == 16'(NUM_SAMPLES)) ? ST_DONE : ST_WAIT_REQ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sample_idx_q    <= '0;
            base_q          <= '0;
            addr_q          <= '0;
            rd_cnt_q        <= '0;
            req_pend_q      <= 1'b0;
            infer_q         <= 1'b0;
            rd_d1_q         <= 1'b0;
            first_d1_q      <= 1'b0;
            bin_cnt_q       <= '0;
            trans_start_q   <= 1'b0;
            result_valid_q  <= 1'b0;
            result_idx_q    <= '0;
            result_winner_q <= '0;
            batch_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_idx_q   <= sample_idx_d;
            base_q         <= base_d;
            addr_q         <= addr_d;
            rd_cnt_q       <= rd_cnt_d;
            req_pend_q     <= req_pend_d;
            infer_q        <= infer_ready;
            // rom_data is valid the cycle after a read; gate it so idle cycles show 0.
            rd_d1_q        <= rd_en;
            first_d1_q     <= (state_q == ST_FETCH);
            bin_cnt_q      <= rd_d1_q ? rom_data : 20'd0;
            trans_start_q  <= first_d1_q;
            result_valid_q <= capture;
            if (capture) begin
                result_idx_q    <= sample_idx_q;
                result_winner_q <= winner_ID;
            end
            batch_done_q   <= (state_q == ST_DONE);
        end
    end

    assign rom_rd_en     = rd_en;
    assign rom_addr      = addr_q;
    assign trans_start   = trans_start_q;
    assign bin_cnt       = bin_cnt_q;
    assign busy          = (state_q != ST_IDLE);
    assign result_valid  = result_valid_q;
    assign result_idx    = result_idx_q;
    assign result_winner = result_winner_q;
    assign batch_done    = batch_done_q;

`ifdef LABEL_CHECK_EN
    logic        result_correct_q;
    logic [15:0] correct_cnt_q;
    logic        label_match;

    assign label_match = (winner_ID == label_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            result_correct_q <= 1'b0;
            correct_cnt_q    <= '0;
        end else begin
            if (capture)
                result_correct_q <= label_match;
            if ((state_q == ST_IDLE) && run)
                correct_cnt_q <= '0;
            else if (capture && label_match && (correct_cnt_q != 16'hFFFF))
                correct_cnt_q <= correct_cnt_q + 16'd1;
        end
    end

    assign label_addr     = sample_idx_q;
    assign result_correct = result_correct_q;
    assign correct_cnt    = correct_cnt_q;
`endif

endmodule

// File: tb/tb_bin_count_sample_streamer.sv
// Directed-plus-random bench for bin_count_sample_streamer: ROM model, burst timing, result capture, abort by reset.
// Label scoring checks are compiled when LABEL_CHECK_EN is defined.
module tb_bin_count_sample_streamer;
    localparam int NB = 1024;
    localparam int NS = 3;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [19:0]   rom_data = '0;
    logic          request_new_sample = 1'b0;
    logic          infer_ready = 1'b0;
    logic [4:0]    winner_ID = '0;
    logic          trans_start;
    logic [19:0]   bin_cnt;
    logic          busy;
    logic          result_valid;
    logic [15:0]   result_idx;
    logic [4:0]    result_winner;
    logic          batch_done;
`ifdef LABEL_CHECK_EN
    logic [15:0]   label_addr;
    logic [4:0]    label_data;
    logic          result_correct;
    logic [15:0]   correct_cnt;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [19:0] rom_key = '0;
    logic [4:0]  labels [NS];
    int          exp_correct = 0;

    bin_count_sample_streamer #(.NUM_BINS(NB), .NUM_SAMPLES(NS), .ROM_AW(AW)) dut (
        .clk(clk), .rst(rst), .run(run),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .request_new_sample(request_new_sample), .infer_ready(infer_ready), .winner_ID(winner_ID),
        .trans_start(trans_start), .bin_cnt(bin_cnt), .busy(busy),
        .result_valid(result_valid), .result_idx(result_idx), .result_winner(result_winner),
`ifdef LABEL_CHECK_EN
        .label_addr(label_addr), .label_data(label_data),
        .result_correct(result_correct), .correct_cnt(correct_cnt),
`endif
        .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] word(input int a);
        return 20'(a) ^ rom_key;
    endfunction

    // Synchronous sample ROM: data valid one cycle after the read enable.
    always @(posedge clk) if (rom_rd_en) rom_data <= word(int'(rom_addr));

`ifdef LABEL_CHECK_EN
    assign label_data = (label_addr < 16'(NS)) ? labels[label_addr] : 5'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rom_rd_en"}, 32'(rom_rd_en), 0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_trans_start"}, 32'(trans_start), 0);
        chk({tag, "_bin_cnt"}, 32'(bin_cnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_result_valid"}, 32'(result_valid), 0);
        chk({tag, "_result_idx"}, 32'(result_idx), 0);
        chk({tag, "_result_winner"}, 32'(result_winner), 0);
        chk({tag, "_batch_done"}, 32'(batch_done), 0);
`ifdef LABEL_CHECK_EN
        chk({tag, "_label_addr"}, 32'(label_addr), 0);
        chk({tag, "_result_correct"}, 32'(result_correct), 0);
        chk({tag, "_correct_cnt"}, 32'(correct_cnt), 0);
`endif
    endtask

    // Called in the cycle the request is seen (t); ends in the first WAIT_RES cycle (t+NB+3),
    // or right after a reset pulse issued when bin abort_at is on bin_cnt.
    task automatic burst(input int s, input bit rand_req, input int abort_at);
        int base;
        logic [19:0] exp_bin;
        base = s * NB;
        for (int c = 1; c <= NB + 3; c++) begin
            tick();
            request_new_sample = (rand_req && c <= NB + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_bin = (c >= 3 && c < NB + 3) ? word(base + c - 3) : 20'd0;
            chk("trans_start", 32'(trans_start), 32'(c == 3));
            chk("bin_cnt", 32'(bin_cnt), 32'(exp_bin));
            chk("rom_rd_en", 32'(rom_rd_en), 32'(c <= NB));
            if (c <= NB) chk("rom_addr", 32'(rom_addr), 32'(base + c - 1));
            chk("busy_stream", 32'(busy), 1);
            if (abort_at >= 0 && c == 3 + abort_at) begin
                request_new_sample = 1'b0;
                rst = 1'b1;
                tick();
                check_zero("abort");
                rst = 1'b0;
                $display("burst sample=%0d aborted at bin %0d", s, abort_at);
                return;
            end
        end
        $display("burst sample=%0d base=%0d done", s, base);
    endtask

    // Called in a WAIT_RES cycle with infer_ready low for at least the previous cycle.
    task automatic result(input int s, input logic [4:0] w, input bit req_with, input int pre_wait);
        for (int i = 0; i < pre_wait; i++) begin
            tick();
            chk("no_early_result", 32'(result_valid), 0);
            chk("no_read_wait_res", 32'(rom_rd_en), 0);
        end
`ifdef LABEL_CHECK_EN
        chk("label_addr", 32'(label_addr), 32'(s));
        if (w == labels[s]) exp_correct++;
`endif
        infer_ready = 1'b1;
        winner_ID = w;
        request_new_sample = req_with;
        tick();
        infer_ready = 1'b0;
        request_new_sample = 1'b0;
        winner_ID = 5'($urandom);
        chk("result_valid", 32'(result_valid), 1);
        chk("result_idx", 32'(result_idx), 32'(s));
        chk("result_winner", 32'(result_winner), 32'(w));
`ifdef LABEL_CHECK_EN
        chk("result_correct", 32'(result_correct), 32'(w == labels[s]));
        chk("correct_cnt", 32'(correct_cnt), 32'(exp_correct));
`endif
        $display("result sample=%0d winner=%0d", s, w);
        if (s == NS - 1) begin
            chk("batch_done_early", 32'(batch_done), 0);
            tick();
            chk("batch_done", 32'(batch_done), 1);
            chk("busy_after_done", 32'(busy), 0);
            tick();
            chk("batch_done_pulse", 32'(batch_done), 0);
        end else begin
            chk("result_pulse_busy", 32'(busy), 1);
        end
    endtask

    initial begin
        bit          rw;
        logic [4:0]  w;
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;

        // Batch 1: ROM word = address.
        rom_key = '0;
        labels[0] = 5'd5; labels[1] = 5'd3; labels[2] = 5'd0;
        exp_correct = 0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("idle_wait_req_rd", 32'(rom_rd_en), 0);
            chk("busy_wait_req", 32'(busy), 1);
        end
        request_new_sample = 1'b1;
        burst(0, 1'b0, -1);
        result(0, 5'd5, 1'b1, 2);
        burst(1, 1'b1, -1);
        result(1, 5'd17, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_extra_burst", 32'(rom_rd_en), 0);
        end
        infer_ready = 1'b1;
        request_new_sample = 1'b1;
        burst(2, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_infer_no_capture", 32'(result_valid), 0);
        end
        infer_ready = 1'b0;
        tick();
        chk("held_infer_low", 32'(result_valid), 0);
        result(2, 5'd0, 1'b0, 0);

        // Batch 2: random ROM contents, labels and winners; reset aborts the first burst.
        rom_key = 20'($urandom);
        for (int i = 0; i < NS; i++) labels[i] = 5'($urandom);
        run = 1'b1;
        tick();
        run = 1'b0;
        request_new_sample = 1'b1;
        burst(0, 1'b1, 500);
        exp_correct = 0;
        run = 1'b1;
        request_new_sample = 1'b1;
        tick();
        run = 1'b0;
        request_new_sample = 1'b0;
        chk("restart_busy", 32'(busy), 1);
        burst(0, 1'b1, -1);
        for (int s = 0; s < NS; s++) begin
            w  = ($urandom_range(0, 1) == 1) ? labels[s] : 5'($urandom);
            rw = (s < NS - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            result(s, w, rw, int'($urandom_range(0, 5)));
            if (s < NS - 1) begin
                if (!rw) begin
                    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                        tick();
                        chk("wait_req_idle_rd", 32'(rom_rd_en), 0);
                    end
                    request_new_sample = 1'b1;
                end
                burst(s + 1, 1'b1, -1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin_count_sample_streamer.md
Name: bin_count_sample_streamer

Overview:
- Host-side transmitter for the bin-ratio spiking network's sample input interface.
- Reads stored spectra (NUM_BINS 20-bit bin counts per sample) from a synchronous sample ROM.
- Answers each request_new_sample from the network with a trans_start pulse and a contiguous one-bin-per-cycle bin_cnt burst.
- Captures winner_ID on each infer_ready and reports one result per sample until NUM_SAMPLES samples are done. Used in FPGA test harnesses and in the system bench.

Parameters:
NUM_BINS, 1024, bin counts per sample; one burst length.
NUM_SAMPLES, 100, samples per batch.
ROM_AW, 17, sample ROM address width; must satisfy 2^ROM_AW >= NUM_SAMPLES*NUM_BINS.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  start-batch pulse; honoured only in IDLE
rom_rd_en  out  1  sample ROM read enable
rom_addr  out  ROM_AW  sample ROM address = sample_idx*NUM_BINS + bin
rom_data  in  20  ROM read data; valid exactly 1 cycle after rom_rd_en
request_new_sample  in  1  network ready for a new sample (pulse or level)
infer_ready  in  1  network result valid (level)
winner_ID  in  5  network classification
trans_start  out  1  one-cycle pulse coincident with bin 0 on bin_cnt
bin_cnt  out  20  registered bin count stream
busy  out  1  state != IDLE
result_valid  out  1  one-cycle pulse per captured result
result_idx  out  16  index of the sample just classified
result_winner  out  5  captured winner_ID
batch_done  out  1  one-cycle pulse after the last result

Behaviour:
- Reset values: every output 0; state IDLE; sample_idx 0; req_pend 0; infer_ready history 0. Reset mid-burst aborts immediately; no partial burst resumes.
- States: IDLE, WAIT_REQ, FETCH, STREAM, WAIT_RES, DONE.
- req_pend:
  - Set by request_new_sample=1 in IDLE, WAIT_REQ, WAIT_RES or DONE.
  - Ignored in FETCH/STREAM.
  - Cleared on entry to FETCH.
  - This allows a pulse-style request to arrive before or with the result.
- IDLE -> WAIT_REQ on run=1. sample_idx := 0. req_pend is kept.
- WAIT_REQ -> FETCH when req_pend=1 or request_new_sample=1.
- FETCH (1 cycle): rom_rd_en=1, rom_addr = base of sample_idx.
- STREAM:
  - rom_rd_en stays high and rom_addr increments for NUM_BINS total reads.
  - rom_data is registered into bin_cnt.
  - Timing: request seen at cycle t -> first read at t+1 -> rom_data at t+2 -> bin_cnt = bin0 and trans_start=1 at t+3.
  - bin k appears at t+3+k with no gaps. bin_cnt returns to 0 at t+3+NUM_BINS, then -> WAIT_RES.
- WAIT_RES:
  - On a rising edge of infer_ready (high now, low last cycle), capture winner_ID into result_winner and sample_idx into result_idx; pulse result_valid; increment sample_idx.
  - Then -> DONE if the new sample_idx == NUM_SAMPLES, else -> WAIT_REQ.
  - If infer_ready is already high on entry with no prior low cycle, wait for a new edge.
- DONE (1 cycle): batch_done=1 -> IDLE.
- infer_ready outside WAIT_RES: ignored, but its history register is still updated.
- run outside IDLE: ignored.
- Address arithmetic: base is accumulated by +NUM_BINS per sample, with no multiplier. There is no wrap; the parameter rule guarantees range.

Optional Feature:
Macro LABEL_CHECK_EN.
- Defined:
  - Adds output label_addr[15:0] (= sample_idx, combinational from the register).
  - Adds input label_data[4:0], valid the same cycle as label_addr.
  - Adds outputs result_correct (1) and correct_cnt (16).
  - At result capture: result_correct = (winner_ID == label_data).
  - correct_cnt increments when correct, clears on rst and on run in IDLE, and saturates at 0xFFFF.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- rst, run, request_new_sample pulse at cycle t, ROM word = address -> trans_start only at t+3; bin_cnt = 0,1,...,1023 over t+3..t+1026; bin_cnt = 0 at t+1027.
- NUM_SAMPLES=3, infer_ready edges with winner_ID 5, 17, 0 -> result_valid x3, result_idx 0,1,2, result_winner 5,17,0; batch_done one cycle after the third result; busy 0 afterwards.
- request_new_sample pulsed in the same cycle as the infer_ready edge for sample 0 -> result captured, then sample 1 burst starts from rom_addr 1024 with no second request.
- infer_ready held high across WAIT_REQ into WAIT_RES -> no capture until it drops and rises again; request pulses during STREAM -> no extra burst.
- rst asserted at bin 500 -> next cycle all outputs 0, state IDLE; run plus request -> burst restarts at rom_addr 0.
- LABEL_CHECK_EN, labels 5, 3, 0 versus winners 5, 17, 0 -> result_correct 1, 0, 1; correct_cnt = 2.
